// File: rtl/wisc_mem_pkg.sv
// Shared types and constants for the WISC-S25 main-memory arbiter.
package wisc_mem_pkg;

  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned CNT_W      = 4;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational grant decision between the fetch and data ports.
// favor_i carries the policy state: starvation limit reached (fixed
// priority) or data granted last (round-robin).
module arb_pick (
  input  logic i_req,
  input  logic d_req,
  input  logic favor_i,
  output logic grant_i,
  output logic grant_d
);

  // Data wins a tie unless the policy currently favours fetch
  always_comb begin
    grant_d = d_req & (~i_req | ~favor_i);
    grant_i = i_req & (~d_req | favor_i);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Unified main-memory arbiter for the WISC-S25 fetch and data ports.
// Optional build macro ARB_RR_EN: round-robin between simultaneous
// requests instead of data priority with a fetch starvation guard.
module mem_arbiter
  import wisc_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              busy
);

  state_t state;
  logic   grant_i;
  logic   grant_d;
  logic   favor_i;

  arb_pick u_pick (
    .i_req   (i_req),
    .d_req   (d_req),
    .favor_i (favor_i),
    .grant_i (grant_i),
    .grant_d (grant_d)
  );

`ifdef ARB_RR_EN
  logic last_grant;

  assign favor_i = (last_grant == PORT_D);

  // Remember which port won the last grant; starts as fetch so data goes first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= PORT_I;
    end else if (state == IDLE) begin
      if (grant_d)      last_grant <= PORT_D;
      else if (grant_i) last_grant <= PORT_I;
    end
  end
`else
  logic [CNT_W-1:0] starve_cnt;

  assign favor_i = (starve_cnt == CNT_W'(STARVE_MAX));

  // Count data grants that bypass a waiting fetch; any fetch grant clears it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (grant_i)
        starve_cnt <= '0;
      else if (grant_d && i_req && !favor_i)
        starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end
`endif

  // Transaction sequencer: grant, one-cycle command, wait for memory, ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      mem_en <= 1'b0;
      i_ack  <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            state     <= D_BUSY;
            mem_en    <= 1'b1;
            mem_wr    <= d_wr;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
          end else if (grant_i) begin
            state    <= I_BUSY;
            mem_en   <= 1'b1;
            mem_wr   <= 1'b0;
            mem_addr <= i_addr;
          end
        end
        I_BUSY: begin
          if (mem_valid) begin
            i_rdata <= mem_rdata;
            i_ack   <= 1'b1;
            state   <= RESP;
          end
        end
        D_BUSY: begin
          // mem_wr still holds the command type of the in-flight access
          if (mem_valid) begin
            if (!mem_wr) d_rdata <= mem_rdata;
            d_ack <= 1'b1;
            state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign stall_if  = i_req & ~i_ack;
  assign stall_mem = d_req & ~d_ack;
  assign busy      = (state != IDLE);

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single multi-cycle unified main memory between the instruction-fetch port and the data port (LW/SW) of the WISC-S25 pipeline.
- Arbitrates between the two ports and sequences one memory transaction at a time.
- Returns read data and acknowledgements to the requester.
- Generates the fetch and memory-stage stall signals the pipeline control uses to freeze stages.

Parameters:
- ADDR_W, 16, byte address width.
- DATA_W, 16, word width.
- STARVE_MAX, 4, consecutive data grants that may occur while fetch is pending before fetch is forced to win; range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- i_req  in  1  fetch read request, level, held until i_ack
- i_addr  in  ADDR_W  fetch address, stable while i_req
- i_ack  out  1  one-cycle pulse, fetch complete
- i_rdata  out  DATA_W  fetch data, valid with i_ack, held until next i_ack
- d_req  in  1  data request, level, held until d_ack
- d_wr  in  1  1 = store (SW), 0 = load (LW); stable while d_req
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_ack  out  1  one-cycle pulse, data transaction complete
- d_rdata  out  DATA_W  load data, valid with d_ack, held
- mem_en  out  1  one-cycle command strobe to memory
- mem_wr  out  1  write command, qualified by mem_en
- mem_addr  out  ADDR_W  command address
- mem_wdata  out  DATA_W  command write data
- mem_rdata  in  DATA_W  memory read data
- mem_valid  in  1  memory completion pulse, for both read and write
- stall_if  out  1  i_req & ~i_ack, combinational
- stall_mem  out  1  d_req & ~d_ack, combinational
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (asynchronous, active-high):
  - FSM goes to IDLE; starve_cnt clears to 0.
  - All registered outputs clear to 0: i_ack, d_ack, mem_en, mem_wr, mem_addr, mem_wdata, i_rdata, d_rdata.
  - Reset mid-transaction abandons it; a later mem_valid seen in IDLE is ignored.
- FSM states: IDLE, I_BUSY, D_BUSY, RESP.
- IDLE arbitration, sampled each cycle:
  - d_req only: grant data.
  - i_req only: grant fetch.
  - Both: data wins unless starve_cnt == STARVE_MAX, then fetch wins.
  - On a grant, the next cycle has mem_en=1 for exactly one cycle, carrying the granted port's addr/wr/wdata (fetch: mem_wr=0). The FSM moves to I_BUSY or D_BUSY.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) on each data grant made while i_req=1.
  - Clears on any fetch grant.
- I_BUSY / D_BUSY: wait for mem_valid with no timeout. On mem_valid, capture mem_rdata into i_rdata, or into d_rdata when d_wr=0; d_rdata is unchanged on a store. Go to RESP.
- RESP: the matching ack is 1 for this cycle only, then the FSM returns to IDLE. Requests are never sampled in RESP, so a requester dropping req the cycle after ack cannot be double-issued.
- Minimum transaction is 3 cycles plus memory latency: grant edge, command cycle, then wait, RESP.
- mem_valid outside I_BUSY/D_BUSY is ignored.
- A req dropped before ack is a protocol violation. The in-flight transaction still completes and acks.
- Exactly one of i_ack / d_ack is ever asserted at a time.

Optional Feature:
- ARB_RR_EN defined:
  - Simultaneous requests alternate by round-robin; a last_grant flop resets to "fetch", so data wins first.
  - The starvation counter and STARVE_MAX are not instantiated.
- ARB_RR_EN undefined: fixed data priority with the starvation guard above.

Decomposition:
- Package wisc_mem_pkg holds:
  - the FSM state enum (IDLE, I_BUSY, D_BUSY, RESP);
  - the port-id constants PORT_I / PORT_D;
  - default ADDR_W and DATA_W.
- One natural sub-module, arb_pick: the combinational grant decision, taking i_req, d_req, the starve/round-robin state and the policy, and producing grant_i and grant_d.
- The FSM, datapath capture and counters stay in mem_arbiter.

Test Plan:
- Reset mid-transaction:
  - Stimulus: i_req at 0x0010; assert rst during I_BUSY; release; mem_valid arrives.
  - Required: all outputs 0, no i_ack; after fetch is re-requested, one clean transaction completes.
- Single fetch:
  - Stimulus: i_req, i_addr=0x0010; memory returns 0xBEEF 3 cycles after mem_en.
  - Required: one mem_en with mem_wr=0 and mem_addr=0x0010; i_ack pulses once with i_rdata=0xBEEF; stall_if high until the i_ack cycle.
- Store then load:
  - Stimulus: d_wr=1, d_addr=0x0100, d_wdata=0x1234; then d_wr=0 at the same address, memory returns 0x1234.
  - Required: two d_ack pulses; d_rdata unchanged after the store and 0x1234 after the load.
- Simultaneous requests, fixed priority, STARVE_MAX=2:
  - Stimulus: i_req held high; d_req re-asserted every cycle after each d_ack.
  - Required: grant order D, D, I, D, D, I.
- Round-robin (ARB_RR_EN defined):
  - Stimulus: both requests continuously pending.
  - Required: grants alternate D, I, D, I.
- Stray mem_valid:
  - Stimulus: mem_valid pulse while in IDLE.
  - Required: no ack, no change to i_rdata/d_rdata, busy stays 0.
